// File: rtl/mcp01_stack_unit.sv
// Purpose: LIFO operand stack serving the MCP01 controller's push/pop/tos strobes, with sticky overflow/underflow flags.
// Latency: d_out, count, empty and full update one clock edge after the strobe; error flags set on the strobe edge.
// Backpressure: none; pushes while full and reads while empty are dropped and recorded in the sticky flags.
module mcp01_stack_unit #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       tos,
    input  logic [DATA_W-1:0]          d_in,
    output logic [DATA_W-1:0]          d_out,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int SP_W  = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [SP_W-1:0] DEPTH_C = SP_W'(DEPTH);
    localparam logic [SP_W-1:0] ONE_C   = SP_W'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [SP_W-1:0]   sp_q, sp_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic              is_empty, is_full;
    logic [IDX_W-1:0]  top_idx;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;

    assign is_empty = (sp_q == '0);
    assign is_full  = (sp_q == DEPTH_C);
    // Only meaningful when the stack is non-empty; never used otherwise.
    assign top_idx  = IDX_W'(sp_q - ONE_C);

    // Next-state decode: read path first, then either an in-place top replace or a plain push/pop.
    always_comb begin
        sp_d   = sp_q;
        dout_d = dout_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        wr_en  = 1'b0;
        wr_idx = sp_q[IDX_W-1:0];

        // pop and tos both read the current top; pop taking priority changes nothing here.
        if (pop || tos) begin
            if (is_empty) begin
                unf_d = 1'b1;
            end else begin
                dout_d = mem_q[top_idx];
            end
        end

        if (push && pop && !is_empty) begin
            // Replace the top in place: legal even when full, so no overflow.
            wr_en  = 1'b1;
            wr_idx = top_idx;
        end else begin
            if (pop && !is_empty) begin
                sp_d = sp_q - ONE_C;
            end
            if (push) begin
                if (is_full) begin
                    ovf_d = 1'b1;
                end else begin
                    wr_en  = 1'b1;
                    wr_idx = sp_q[IDX_W-1:0];
                    sp_d   = sp_q + ONE_C;
                end
            end
        end
    end

    // Pointer, read data and sticky flags; reset discards all entries and overrides strobes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sp_q   <= '0;
            dout_q <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            sp_q   <= sp_d;
            dout_q <= dout_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    // Storage array is left uncleared; stale entries are unreachable because reads require sp > 0.
    always_ff @(posedge clk) begin
        if (rst && wr_en) begin
            mem_q[wr_idx] <= d_in;
        end
    end

    assign d_out     = dout_q;
    assign count     = sp_q;
    assign empty     = is_empty;
    assign full      = is_full;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: doc/mcp01_stack_unit.md
# mcp01_stack_unit

Hardware operand stack that answers the MCP01 controller's `push`/`pop`/`tos` strobes. It is the storage end of the stack interface the controller drives: it accepts operands from the datapath's `d_in` mux and returns popped or peeked values to the operand registers (`ldop1`/`ldop2` load path). The block is fully synchronous. It holds LIFO storage, a stack pointer, and occupancy status, and it reports overflow and underflow errors as sticky flags.

## Interface
- `DATA_W`, default 8: operand width in bits.
- `DEPTH`, default 16: number of stack entries, ≥ 2, need not be a power of 2.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `push`  in  1: single-cycle strobe; write `d_in` onto the stack.
- `pop`  in  1: single-cycle strobe; remove the top entry and return it on `d_out`.
- `tos`  in  1: single-cycle strobe; return the top entry on `d_out` without removing it.
- `d_in`  in  DATA_W: push data, sampled on the edge where `push` is high.
- `d_out`  out  DATA_W: registered read data; holds its value until the next successful `pop`/`tos`.
- `empty`  out  1: high when `count` == 0.
- `full`  out  1: high when `count` == DEPTH.
- `count`  out  clog2(DEPTH+1): number of valid entries.
- `overflow`  out  1: sticky; set by a push while full.
- `underflow`  out  1: sticky; set by a pop or tos while empty.

## Operation
- Storage: `mem[0..DEPTH-1]` plus a pointer `sp` with range 0..DEPTH; `count` = `sp`. The top of stack is `mem[sp-1]`.
- Reset (`rst`=0 at an edge):
  - `sp` = 0, `d_out` = 0, `overflow` = 0, `underflow` = 0, so `empty` = 1 and `full` = 0.
  - `mem` is not cleared. Stale contents are never observable because reads require `sp` > 0.
- Reset overrides all strobes in the same cycle. Reset mid-sequence discards all entries.
- Status is derived combinationally from `sp`, giving three states:
  - EMPTY (`sp` = 0)
  - PARTIAL (0 < `sp` < DEPTH)
  - FULL (`sp` = DEPTH)
  - Transitions: only a successful push moves the state up; only a successful pop moves it down.
- Single strobes:
  - push, not full: `mem[sp]` <= `d_in`; `sp` <= `sp`+1.
  - push, full: no write, `sp` unchanged, `overflow` <= 1.
  - pop, not empty: `d_out` <= `mem[sp-1]`; `sp` <= `sp`-1.
  - pop, empty: `d_out` and `sp` unchanged, `underflow` <= 1.
  - tos, not empty: `d_out` <= `mem[sp-1]`; `sp` unchanged.
  - tos, empty: `d_out` unchanged, `underflow` <= 1.
- Simultaneous strobes:
  - `pop` and `tos`: `pop` wins; `tos` is ignored.
  - push+pop, not empty: `d_out` <= old top; `mem[sp-1]` <= `d_in`; `sp` unchanged. The top entry is replaced.
  - push+pop, empty: the push proceeds (`sp` = 1), the pop fails, `underflow` <= 1, and `d_out` is unchanged.
  - push+pop, full: the replace proceeds. It is legal and sets no `overflow`.
  - push+tos, not empty: `d_out` <= old top (the value before the push), then the push proceeds normally under the full/not-full rules.
  - push+tos, empty: the push proceeds, `underflow` <= 1.
- `overflow` and `underflow` clear only on reset.
- Arithmetic: `sp` never wraps. Increment and decrement are blocked at DEPTH and 0 respectively.

## Timing
- All outputs are registered or derived from registers; there is no combinational path from strobes to outputs.
- `d_out` is valid the cycle after the strobe edge. The controller may load `op1`/`op2` from it in the next state.
- `count`, `empty`, and `full` reflect the operation one edge after the strobe. Back-to-back strobes on consecutive cycles are fully supported.
- Error flags assert on the same edge as the offending strobe.

## Test plan
- Reset then idle: `count`=0, `empty`=1, `full`=0, `d_out`=0x00, both flags 0.
- With DEPTH=4: push 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> `full`=1, `count`=4. A fifth push of 0x55 -> `overflow`=1, `count`=4. Then pop ×4 -> `d_out` = 0x44, 0x33, 0x22, 0x11, `empty`=1.
- Pop on an empty stack -> `underflow`=1, `d_out` unchanged, `count`=0. The flag stays 1 until `rst`=0.
- Push 0xA5 then `tos` -> `d_out`=0xA5, `count`=1. A following pop -> `d_out`=0xA5, `count`=0.
- Stack [0x10, 0x20] (0x20 on top). Push+pop with `d_in`=0x30 -> `d_out`=0x20, `count`=2. Next `tos` -> 0x30. With the stack full, push+pop -> replace, `overflow` stays 0.
- Push 0x01, 0x02, then `rst`=0 for one cycle together with `push`=1 -> `count`=0, `d_out`=0, no write. A subsequent `tos` -> `underflow`=1.
